uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl_pkg.sv | 21 ++
 rtl/uart_cmd_ctrl_byte_timeout.sv | 38 +++
 rtl/uart_cmd_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: FSM states, command
// byte layout and frame/response lengths.
package uart_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_DHI,
        S_DLO,
        S_EXEC,
        S_RDWAIT,
        S_TX0,
        S_TX1,
        S_TX2
    } state_t;

    localparam int unsigned CMD_WR_BIT  = 6;
    localparam int unsigned CMD_RSV_BIT = 7;
    localparam int unsigned FRAME_LEN   = 3;
    localparam int unsigned RESP_LEN    = 3;

endpackage

// File: rtl/uart_cmd_ctrl_byte_timeout.sv
// Inter-byte idle counter; saturates at TIMEOUT_CYC and flags the cycle that
// completes TIMEOUT_CYC consecutive enabled cycles without a clear.
module byte_timeout #(
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic clk100,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the idle cycles already elapsed, so the current cycle is the last one at LIMIT-1
    assign expired = enable && (cnt_q >= LIMIT - 1'b1);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses 3-byte CMD/DHI/DLO frames into memory
// writes, or reads that are answered with a 3-byte CMD/RHI/RLO response.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              rx_overrun,
    output logic              frame_err
);

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic [15:0] rdata_q, rdata_d;
    logic        overrun_q, overrun_d;
    logic        ferr_q, ferr_d;
    logic        in_frame;
    logic        timeout_hit;

    assign in_frame = (state_q == S_DHI) || (state_q == S_DLO);

    byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk100 (clk100),
        .rst    (rst),
        .clear  (rx_valid || !in_frame),
        .enable (in_frame),
        .expired(timeout_hit)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        dhi_d     = dhi_q;
        dlo_d     = dlo_q;
        rdata_d   = rdata_q;
        overrun_d = overrun_q;
        ferr_d    = ferr_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        case (state_q)
            S_CMD: begin
                if (rx_valid) begin
                    if (rx_data[CMD_RSV_BIT]) begin
                        ferr_d = 1'b1;
                    end else begin
                        cmd_d   = rx_data;
                        state_d = S_DHI;
                    end
                end
            end
            S_DHI: begin
                if (rx_valid) begin
                    dhi_d   = rx_data;
                    state_d = S_DLO;
                end else if (timeout_hit) begin
                    ferr_d  = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_DLO: begin
                if (rx_valid) begin
                    dlo_d   = rx_data;
                    state_d = S_EXEC;
                end else if (timeout_hit) begin
                    ferr_d  = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_EXEC: begin
                if (cmd_q[CMD_WR_BIT]) begin
                    mem_we  = 1'b1;
                    state_d = S_CMD;
                end else begin
                    mem_re  = 1'b1;
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                rdata_d = mem_rdata;
                state_d = S_TX0;
            end
            S_TX0: begin
                tx_valid = 1'b1;
                tx_data  = cmd_q;
                if (tx_ready) state_d = S_TX1;
            end
            S_TX1: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[15:8];
                if (tx_ready) state_d = S_TX2;
            end
            S_TX2: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[7:0];
                if (tx_ready) state_d = S_CMD;
            end
            default: state_d = S_CMD;
        endcase

        // Bytes arriving while a command is executing or answering are dropped
        if (rx_valid && !in_frame && (state_q != S_CMD)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q   <= S_CMD;
            cmd_q     <= '0;
            dhi_q     <= '0;
            dlo_q     <= '0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            dhi_q     <= dhi_d;
            dlo_q     <= dlo_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign mem_addr   = ADDR_W'(cmd_q[5:0]);
    assign mem_wdata  = {dhi_q, dlo_q};
    assign busy       = (state_q != S_CMD);
    assign rx_overrun = overrun_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: table-driven frames, directed corner
// sequences and a randomized run against a frame-level reference model.
module tb_uart_cmd_ctrl;

    localparam int unsigned T = 50;

    logic        clk100 = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        rx_overrun;
    logic        frame_err;

    always #5 clk100 = ~clk100;

    uart_cmd_ctrl #(
        .ADDR_W     (6),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk100    (clk100),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .rx_overrun(rx_overrun),
        .frame_err (frame_err)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: read data valid exactly one cycle after mem_re, noise otherwise
    logic [15:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 257) ^ 16'hA5A5;
        mem_rdata = '0;
        forever begin
            @(posedge clk100);
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem_re ? mem[mem_addr] : 16'($urandom);
        end
    end

    // Transmitter ready: 0 = always ready, 1 = random, 2 = 10 stall cycles per byte
    int txmode = 0;
    initial begin
        int stall_cnt = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk100);
            #1;
            if (txmode == 0) begin
                tx_ready = 1'b1;
            end else if (txmode == 1) begin
                tx_ready = 1'($urandom_range(0, 1));
            end else if (!tx_valid) begin
                tx_ready  = 1'b0;
                stall_cnt = 0;
            end else if (stall_cnt < 10) begin
                tx_ready  = 1'b0;
                stall_cnt++;
            end else begin
                tx_ready  = 1'b1;
                stall_cnt = 0;
            end
        end
    end

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         act_wr[$];
    logic [7:0]  act_tx[$];
    int unsigned last_we_cyc  = 0;
    int unsigned last_txv_cyc = 0;
    logic        prev_txv     = 1'b0;
    logic        prev_stall   = 1'b0;
    logic [7:0]  prev_txd     = '0;

    // Monitor samples mid-cycle; a handshake seen here completes on the next rising edge
    always @(negedge clk100) begin
        if (!rst) begin
            if (mem_we || mem_re) chk("we_re_exclusive", {31'b0, mem_we && mem_re}, 32'd0);
            if (mem_we) begin
                act_wr.push_back({mem_addr, mem_wdata});
                last_we_cyc = cyc;
            end
            if (prev_stall) begin
                chk("tx_hold_valid", {31'b0, tx_valid}, 32'd1);
                chk("tx_hold_data", {24'b0, tx_data}, {24'b0, prev_txd});
            end
            if (tx_valid && !prev_txv) last_txv_cyc = cyc;
            if (tx_valid && tx_ready) act_tx.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_txd   = tx_data;
            prev_txv   = tx_valid;
        end else begin
            prev_stall = 1'b0;
            prev_txv   = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end at one time unit after a rising edge
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk100);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk100);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (busy && n < budget) begin
            idle(1);
            n++;
        end
        chk(name, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_tx(input string name, input int target, input int unsigned budget);
        int unsigned n = 0;
        while (act_tx.size() < target && n < budget) begin
            idle(1);
            n++;
        end
        chk(name, act_tx.size(), target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ctl_outputs", {26'b0, tx_valid, mem_we, mem_re, busy, rx_overrun, frame_err}, 32'd0);
        chk("rst_data_outputs", {2'b0, tx_data, mem_addr, mem_wdata}, 32'd0);
        idle(2);
        rst = 1'b0;
    endtask

    task automatic chk_tx3(input string name, input int base, input logic [23:0] exp);
        logic [23:0] e;
        e = exp;
        if (act_tx.size() >= base + 3) begin
            chk({name, "_b0"}, {24'b0, act_tx[base]},     {24'b0, e[23:16]});
            chk({name, "_b1"}, {24'b0, act_tx[base + 1]}, {24'b0, e[15:8]});
            chk({name, "_b2"}, {24'b0, act_tx[base + 2]}, {24'b0, e[7:0]});
        end else begin
            chk({name, "_count"}, act_tx.size(), base + 3);
        end
    endtask

    typedef struct packed {
        logic [23:0] bytes;
        logic        is_wr;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [23:0] tx;
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] shadow[64];
    logic        known[64];
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];

    initial begin
        int          nw, nt, nw0, nt0;
        int unsigned dlo_cyc;
        vec_t        v;
        logic        exp_ferr;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        idle(3);
        chk("reset_ctl", {26'b0, tx_valid, mem_we, mem_re, busy, rx_overrun, frame_err}, 32'd0);
        chk("reset_data", {2'b0, tx_data, mem_addr, mem_wdata}, 32'd0);
        rst = 1'b0;
        idle(2);

        vecs[0] = '{24'h400005, 1'b1, 6'd0,  16'h0005, 24'h0};
        vecs[1] = '{24'h425555, 1'b1, 6'd2,  16'h5555, 24'h0};
        vecs[2] = '{24'h020000, 1'b0, 6'd2,  16'h0000, 24'h025555};
        vecs[3] = '{24'h7FABCD, 1'b1, 6'd63, 16'hABCD, 24'h0};
        vecs[4] = '{24'h3F1234, 1'b0, 6'd63, 16'h0000, 24'h3FABCD};
        vecs[5] = '{24'h40FFFF, 1'b1, 6'd0,  16'hFFFF, 24'h0};
        vecs[6] = '{24'h009999, 1'b0, 6'd0,  16'h0000, 24'h00FFFF};

        foreach (vecs[i]) begin
            v  = vecs[i];
            nw = act_wr.size();
            nt = act_tx.size();
            send_byte(v.bytes[23:16]);
            send_byte(v.bytes[15:8]);
            dlo_cyc = cyc;
            send_byte(v.bytes[7:0]);
            wait_idle("row_idle", 40);
            if (v.is_wr) begin
                chk("row_wr_count", act_wr.size() - nw, 1);
                chk("row_tx_count", act_tx.size() - nt, 0);
                if (act_wr.size() > nw) begin
                    chk("row_wr_addr", {26'b0, act_wr[nw].addr}, {26'b0, v.addr});
                    chk("row_wr_data", {16'b0, act_wr[nw].data}, {16'b0, v.wdata});
                end
                chk("row_wr_latency", last_we_cyc, dlo_cyc + 1);
            end else begin
                chk("row_wr_count", act_wr.size() - nw, 0);
                chk_tx3("row_tx", nt, v.tx);
                chk("row_rd_latency", last_txv_cyc, dlo_cyc + 3);
            end
        end
        chk("table_flags", {30'b0, rx_overrun, frame_err}, 32'd0);

        // Read with ten stall cycles on every response byte
        txmode = 2;
        nt = act_tx.size();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        wait_idle("stall_idle", 120);
        chk_tx3("stall_tx", nt, 24'h025555);
        txmode = 0;

        // Byte on the final allowed cycle is still accepted
        nw = act_wr.size();
        send_byte(8'h43);
        idle(T - 1);
        send_byte(8'h11);
        send_byte(8'h22);
        wait_idle("edge_idle", 20);
        chk("edge_wr_count", act_wr.size() - nw, 1);
        if (act_wr.size() > nw) chk("edge_wr", {10'b0, act_wr[nw]}, {10'b0, 6'd3, 16'h1122});
        chk("edge_no_ferr", {31'b0, frame_err}, 32'd0);

        // Full timeout, then recovery
        nw = act_wr.size();
        send_byte(8'h40);
        idle(T - 1);
        chk("to_before", {30'b0, frame_err, busy}, 32'b01);
        idle(1);
        chk("to_after", {30'b0, frame_err, busy}, 32'b10);
        chk("to_no_write", act_wr.size() - nw, 0);
        send_byte(8'h41); send_byte(8'h12); send_byte(8'h34);
        wait_idle("to_rec_idle", 20);
        chk("to_rec_count", act_wr.size() - nw, 1);
        if (act_wr.size() > nw) chk("to_rec_wr", {10'b0, act_wr[nw]}, {10'b0, 6'd1, 16'h1234});

        // Reserved bit, then an overrun during the second response byte
        do_reset();
        send_byte(8'h80);
        chk("bad_cmd", {29'b0, frame_err, busy, rx_overrun}, 32'b100);
        txmode = 2;
        nw = act_wr.size();
        nt = act_tx.size();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        wait_tx("ovr_first", nt + 1, 60);
        send_byte(8'hC3);
        chk("ovr_flag", {31'b0, rx_overrun}, 32'd1);
        wait_idle("ovr_idle", 80);
        idle(5);
        chk("ovr_tx_count", act_tx.size() - nt, 3);
        chk_tx3("ovr_tx", nt, 24'h025555);
        chk("ovr_wr_count", act_wr.size() - nw, 0);
        chk("ovr_busy", {31'b0, busy}, 32'd0);
        txmode = 0;

        // Reset while waiting for DLO
        nw = act_wr.size();
        nt = act_tx.size();
        send_byte(8'h45); send_byte(8'h01);
        do_reset();
        idle(5);
        chk("rst_dlo_wr", act_wr.size() - nw, 0);
        chk("rst_dlo_tx", act_tx.size() - nt, 0);
        chk("rst_dlo_busy", {31'b0, busy}, 32'd0);

        // Reset while offering the second response byte
        txmode = 2;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        wait_tx("rst_tx1_first", nt + 1, 60);
        do_reset();
        txmode = 0;
        idle(20);
        chk("rst_tx1_tx", act_tx.size() - nt, 1);
        chk("rst_tx1_wr", act_wr.size() - nw, 0);

        // Randomized frames against a frame-level model
        do_reset();
        txmode   = 1;
        exp_ferr = 1'b0;
        nw0      = act_wr.size();
        nt0      = act_tx.size();
        for (int i = 0; i < 64; i++) known[i] = 1'b0;
        for (int f = 0; f < 60; f++) begin
            int unsigned kind;
            logic [5:0]  a;
            logic [15:0] d;
            kind = $urandom_range(0, 9);
            a    = 6'($urandom_range(0, 63));
            d    = 16'($urandom);
            if (kind < 4 || (kind < 8 && !known[a])) begin
                shadow[a] = d;
                known[a]  = 1'b1;
                exp_wr.push_back({a, d});
                send_byte({2'b01, a});      idle($urandom_range(0, 3));
                send_byte(d[15:8]);         idle($urandom_range(0, 3));
                send_byte(d[7:0]);
            end else if (kind < 8) begin
                exp_tx.push_back({2'b00, a});
                exp_tx.push_back(shadow[a][15:8]);
                exp_tx.push_back(shadow[a][7:0]);
                send_byte({2'b00, a});      idle($urandom_range(0, 3));
                send_byte(d[15:8]);         idle($urandom_range(0, 3));
                send_byte(d[7:0]);
            end else if (kind == 8) begin
                exp_ferr = 1'b1;
                send_byte({1'b1, d[6:0]});
            end else begin
                exp_ferr = 1'b1;
                send_byte({1'b0, d[0], a});
                if (d[1]) send_byte(d[15:8]);
                idle(T);
            end
            wait_idle("rnd_idle", 300);
            idle($urandom_range(0, 2));
        end
        chk("rnd_wr_count", act_wr.size() - nw0, exp_wr.size());
        chk("rnd_tx_count", act_tx.size() - nt0, exp_tx.size());
        foreach (exp_wr[i]) begin
            if (nw0 + i < act_wr.size())
                chk("rnd_wr", {10'b0, act_wr[nw0 + i]}, {10'b0, exp_wr[i]});
        end
        foreach (exp_tx[i]) begin
            if (nt0 + i < act_tx.size())
                chk("rnd_tx", {24'b0, act_tx[nt0 + i]}, {24'b0, exp_tx[i]});
        end
        chk("rnd_flags", {30'b0, frame_err, rx_overrun}, {30'b0, exp_ferr, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
